// File: rtl/stream_pkg.sv
// Shared stream types: arbiter FSM states and source encodings.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } rr_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux.sv
// 2:1 data select: sel = 0 passes in_a, sel = 1 passes in_b.
module MUX #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // Pure combinational select.
  always_comb begin
    out = sel ? in_b : in_a;
  end

endmodule

// File: rtl/rr_stream_mux.sv
// Two-input round-robin, packet-aware stream mux with a registered output.
// Handshake: a beat moves on a port in any cycle where valid && ready are both
// high at the rising clock edge; valid never depends on ready, ready may depend
// on the input valids (only while arbitrating in IDLE).
module rr_stream_mux
  import stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             out_src,
  output logic             sel,
  output rr_state_t        dbg_state
);

  rr_state_t        state, state_nxt;
  logic             rr_last, rr_last_nxt;
  logic             grant;
  logic             ld;
  logic             sel_valid;
  logic             sel_last;
  logic             accept;
  logic [WIDTH-1:0] mux_data;

  assign dbg_state = state;

  // Grant: locked source while inside a packet, otherwise round-robin on valids.
  always_comb begin
    grant = rr_last;
    case (state)
      IDLE: begin
        if (a_valid && !b_valid)      grant = SRC_A;
        else if (b_valid && !a_valid) grant = SRC_B;
        else if (a_valid && b_valid)  grant = !rr_last;
        else                          grant = rr_last;
      end
      LOCK_A:  grant = SRC_A;
      LOCK_B:  grant = SRC_B;
      default: grant = rr_last;
    endcase
  end

  // Handshake decode: output slot free or draining this cycle opens the load.
  always_comb begin
    ld        = !out_valid || out_ready;
    sel       = grant;
    a_ready   = rst_n && ld && (grant == SRC_A);
    b_ready   = rst_n && ld && (grant == SRC_B);
    sel_valid = (grant == SRC_B) ? b_valid : a_valid;
    sel_last  = (grant == SRC_B) ? b_last  : a_last;
    accept    = rst_n && ld && sel_valid;
  end

  MUX #(.WIDTH(WIDTH)) u_data_mux (
    .in_a (a_data),
    .in_b (b_data),
    .sel  (sel),
    .out  (mux_data)
  );

  // Next-state: only an accepted beat moves the FSM or the round-robin pointer.
  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    case (state)
      IDLE: begin
        if (accept) begin
          rr_last_nxt = grant;
          if (!sel_last) state_nxt = (grant == SRC_B) ? LOCK_B : LOCK_A;
        end
      end
      LOCK_A, LOCK_B: begin
        if (accept && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM and round-robin pointer; reset leaves B as last served so A wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= SRC_B;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  // Output register: load on accept, drop valid when drained with nothing new.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= SRC_A;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= sel_last;
      out_src   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed per-cycle vector table followed by a
// streaming phase checked against a reference arbiter and an expected queue.
module tb_rr_stream_mux;
  import stream_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_data, b_data, out_data;
  logic         a_valid, a_last, a_ready;
  logic         b_valid, b_last, b_ready;
  logic         out_valid, out_last, out_ready, out_src, sel;
  rr_state_t    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  rr_stream_mux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_src   (out_src),
    .sel       (sel),
    .dbg_state (dbg_state)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         rst_n;
    logic         av;
    logic [W-1:0] ad;
    logic         al;
    logic         bv;
    logic [W-1:0] bd;
    logic         bl;
    logic         ordy;
    logic         e_ar;
    logic         e_br;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic         e_ol;
    logic         e_os;
  } vec_t;

  vec_t vecs[$];

  // Expected output beats: {src, last, data}.
  logic [W+1:0] exp_q[$];

  // Reference arbiter state: 0 idle, 1 locked on A, 2 locked on B.
  int   m_state;
  logic m_rr;
  logic m_ov;

  // Per-source stimulus state.
  logic         src_v[2];
  logic [W-1:0] src_d[2];
  logic         src_l[2];
  int           src_beat[2];
  int           src_len[2];

  logic prev_valid, prev_last, prev_src;

  function automatic vec_t mk(input logic r, input logic av, input logic [W-1:0] ad,
                              input logic al, input logic bv, input logic [W-1:0] bd,
                              input logic bl, input logic ordy, input logic ear,
                              input logic ebr, input logic eov, input logic [W-1:0] eod,
                              input logic eol, input logic eos);
    vec_t v;
    v.rst_n = r;  v.av = av;  v.ad = ad;  v.al = al;
    v.bv = bv;    v.bd = bd;  v.bl = bl;  v.ordy = ordy;
    v.e_ar = ear; v.e_br = ebr;
    v.e_ov = eov; v.e_od = eod; v.e_ol = eol; v.e_os = eos;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: apply one table record and check readies, then registered outputs.
  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    rst_n = v.rst_n;
    a_valid = v.av; a_data = v.ad; a_last = v.al;
    b_valid = v.bv; b_data = v.bd; b_last = v.bl;
    out_ready = v.ordy;
    #1;
    chk($sformatf("vec%0d a_ready", i), 32'(a_ready), 32'(v.e_ar));
    chk($sformatf("vec%0d b_ready", i), 32'(b_ready), 32'(v.e_br));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(v.e_ov));
    chk($sformatf("vec%0d out_data", i),  32'(out_data),  32'(v.e_od));
    chk($sformatf("vec%0d out_last", i),  32'(out_last),  32'(v.e_ol));
    chk($sformatf("vec%0d out_src", i),   32'(out_src),   32'(v.e_os));
  endtask

  task automatic model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    m_state = 0; m_rr = 1'b1; m_ov = 1'b0;
    exp_q.delete();
    prev_valid = 1'b0; prev_last = 1'b0; prev_src = 1'b0;
    for (int s = 0; s < 2; s++) begin
      src_v[s] = 1'b0; src_d[s] = '0; src_l[s] = 1'b0;
      src_beat[s] = 0; src_len[s] = 1;
    end
  endtask

  // One streaming cycle: drive sources, compare against the reference, advance it.
  task automatic stream_cycle(input int pct, input int max_len, input bit rand_rdy,
                              input bit gen_en);
    logic m_ld, m_g, m_ar, m_br, m_acc;
    logic [W+1:0] e;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int s = 0; s < 2; s++) begin
      if (gen_en && !src_v[s] && ($urandom_range(0, 99) < pct)) begin
        if (src_beat[s] == 0) src_len[s] = $urandom_range(1, max_len);
        src_v[s] = 1'b1;
        src_d[s] = W'($urandom_range(0, 255));
        src_l[s] = (src_beat[s] == src_len[s] - 1);
      end
    end
    a_valid = src_v[0]; a_data = src_d[0]; a_last = src_l[0];
    b_valid = src_v[1]; b_data = src_d[1]; b_last = src_l[1];
    #1;
    m_ld = !m_ov || out_ready;
    case (m_state)
      1: m_g = 1'b0;
      2: m_g = 1'b1;
      default: begin
        if (src_v[0] && src_v[1]) m_g = !m_rr;
        else if (src_v[0])        m_g = 1'b0;
        else if (src_v[1])        m_g = 1'b1;
        else                      m_g = m_rr;
      end
    endcase
    m_ar = m_ld && !m_g;
    m_br = m_ld && m_g;
    chk("stream a_ready", 32'(a_ready), 32'(m_ar));
    chk("stream b_ready", 32'(b_ready), 32'(m_br));
    chk("stream out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("stream queue underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("stream beat", 32'({out_src, out_last, out_data}), 32'(e));
        if (prev_valid && !prev_last) chk("packet interleave", 32'(e[W+1]), 32'(prev_src));
        prev_valid = 1'b1; prev_last = e[W]; prev_src = e[W+1];
      end
    end
    m_acc = m_g ? (src_v[1] && m_br) : (src_v[0] && m_ar);
    if (m_acc) begin
      exp_q.push_back({m_g, src_l[m_g], src_d[m_g]});
      m_ov = 1'b1;
      if (m_state == 0) begin
        m_rr = m_g;
        if (!src_l[m_g]) m_state = m_g ? 2 : 1;
      end else if (src_l[m_g]) begin
        m_state = 0;
      end
      src_beat[m_g] = src_l[m_g] ? 0 : src_beat[m_g] + 1;
      src_v[m_g] = 1'b0;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    out_ready = 1'b1;

    // Reset
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0,  0, 8'h00, 0, 0));
    // Single source: A 3-beat packet
    vecs.push_back(mk(1, 1, 8'h11, 0, 0, 8'h00, 0, 1,  1, 0,  1, 8'h11, 0, 0));
    vecs.push_back(mk(1, 1, 8'h22, 0, 0, 8'h00, 0, 1,  1, 0,  1, 8'h22, 0, 0));
    vecs.push_back(mk(1, 1, 8'h33, 1, 0, 8'h00, 0, 1,  1, 0,  1, 8'h33, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 0,  0, 8'h33, 1, 0));
    // Tie after reset: alternate AA, BB, AA, BB
    vecs.push_back(mk(0, 1, 8'hAA, 1, 1, 8'hBB, 1, 1,  0, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 8'hAA, 1, 1, 8'hBB, 1, 1,  1, 0,  1, 8'hAA, 1, 0));
    vecs.push_back(mk(1, 1, 8'hAA, 1, 1, 8'hBB, 1, 1,  0, 1,  1, 8'hBB, 1, 1));
    vecs.push_back(mk(1, 1, 8'hAA, 1, 1, 8'hBB, 1, 1,  1, 0,  1, 8'hAA, 1, 0));
    vecs.push_back(mk(1, 1, 8'hAA, 1, 1, 8'hBB, 1, 1,  0, 1,  1, 8'hBB, 1, 1));
    // Lock: A 4-beat packet with a 2-cycle gap, B waiting
    vecs.push_back(mk(1, 1, 8'h41, 0, 1, 8'hB1, 1, 1,  1, 0,  1, 8'h41, 0, 0));
    vecs.push_back(mk(1, 1, 8'h42, 0, 1, 8'hB1, 1, 1,  1, 0,  1, 8'h42, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'hB1, 1, 1,  1, 0,  0, 8'h42, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'hB1, 1, 1,  1, 0,  0, 8'h42, 0, 0));
    vecs.push_back(mk(1, 1, 8'h43, 0, 1, 8'hB1, 1, 1,  1, 0,  1, 8'h43, 0, 0));
    vecs.push_back(mk(1, 1, 8'h44, 1, 1, 8'hB1, 1, 1,  1, 0,  1, 8'h44, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'hB1, 1, 1,  0, 1,  1, 8'hB1, 1, 1));
    // Backpressure: 0x5C held for 3 stalled cycles, 0x5D loads on release
    vecs.push_back(mk(1, 1, 8'h5C, 1, 0, 8'h00, 0, 1,  1, 0,  1, 8'h5C, 1, 0));
    vecs.push_back(mk(1, 1, 8'h5D, 1, 0, 8'h00, 0, 0,  0, 0,  1, 8'h5C, 1, 0));
    vecs.push_back(mk(1, 1, 8'h5D, 1, 0, 8'h00, 0, 0,  0, 0,  1, 8'h5C, 1, 0));
    vecs.push_back(mk(1, 1, 8'h5D, 1, 0, 8'h00, 0, 0,  0, 0,  1, 8'h5C, 1, 0));
    vecs.push_back(mk(1, 1, 8'h5D, 1, 0, 8'h00, 0, 1,  1, 0,  1, 8'h5D, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 0,  0, 8'h5D, 1, 0));
    // Reset mid-packet on B, then A preferred on the tie
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'hC1, 0, 1,  0, 1,  1, 8'hC1, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hC2, 0, 1,  0, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 8'hD1, 1, 1, 8'hC3, 1, 1,  1, 0,  1, 8'hD1, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'hC3, 1, 1,  0, 1,  1, 8'hC3, 1, 1));

    for (int i = 0; i < vecs.size(); i++) apply_vec(i);

    // Full throughput: continuous 2-beat packets on both inputs.
    model_reset();
    for (int c = 0; c < 40; c++) stream_cycle(100, 2, 1'b0, 1'b1);

    // Random valids, packet lengths and backpressure.
    model_reset();
    for (int c = 0; c < 300; c++) stream_cycle(70, 3, 1'b1, 1'b1);

    // Drain pending beats.
    for (int c = 0; c < 12; c++) stream_cycle(0, 1, 1'b0, 1'b0);
    chk("queue empty at end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Two-input, round-robin, packet-aware stream multiplexer with a registered output stage. Arbitrates two valid/ready byte streams onto one output, holds the grant for the full length of a packet (delimited by `last`), and drives the select of the team's existing 2:1 `MUX` data-select block. It sits directly upstream of that select, turning the free `sel` input into a controlled, handshaked datapath.

## Interface
- `WIDTH`, 8: data width of every stream.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `a_data`  in  WIDTH  stream A data.
- `a_valid`  in  1  stream A beat valid.
- `a_last`  in  1  stream A final beat of packet.
- `a_ready`  out  1  stream A beat accepted this cycle when high with `a_valid`.
- `b_data`, `b_valid`, `b_last`, `b_ready`: same as A, for stream B.
- `out_data`  out  WIDTH  registered output data.
- `out_valid`  out  1  output beat valid.
- `out_last`  out  1  output final beat of packet.
- `out_ready`  in  1  downstream accepts beat.
- `out_src`  out  1  source of the current output beat: 0 = A, 1 = B.
- `sel`  out  1  combinational grant driving the data select: 0 = A, 1 = B.

## Operation
- Load enable `ld = !out_valid || out_ready`. Output register loads only when `ld` is high and the granted input is valid.
- `a_ready = ld && (grant == A)`; `b_ready = ld && (grant == B)`. The non-granted input sees `ready = 0`.
- Valid never depends on ready. Ready may depend on both valids in IDLE.
- FSM states:
  - IDLE: grant = sole valid input. If both are valid, grant = `!rr_last`, i.e. the input not served last. If neither is valid, grant = `rr_last`, and no transfer occurs.
  - LOCK_A: grant = A regardless of `b_valid`.
  - LOCK_B: grant = B regardless of `a_valid`.
- Transitions happen on an accepted input beat only:
  - From IDLE: on an accepted beat with `last = 0`, go to LOCK_x for the granted input. On an accepted beat with `last = 1`, stay in IDLE. Both cases set `rr_last` to the granted input.
  - From LOCK_x: on an accepted beat with `last = 1`, go to IDLE. Otherwise stay in LOCK_x.
- If the locked input drops `valid` mid-packet, the lock holds and the other input is starved until the locked input sends `last`.
- Output register update:
  - On load: `out_data` ← selected data, `out_last` ← selected last, `out_src` ← grant, `out_valid` ← 1.
  - If `out_ready` is high and there is no load, `out_valid` ← 0. Data, last and src hold.
  - While `out_valid && !out_ready`, all outputs hold and both readies are 0.

## Timing
- Latency is 1 cycle: a beat accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput is 1 beat per cycle sustained when `out_ready` is held high, including back-to-back packets from alternating sources with no bubble.
- Reset values: `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_src` = 0, state = IDLE, `rr_last` = B (so A wins the first tie).
- While `rst_n` is low, `a_ready` = 0 and `b_ready` = 0.
- Reset mid-packet discards the output beat and the lock. Arbitration restarts from IDLE with A preferred.
- `out_ready` rising in the same cycle as a stall release: the held beat drains and a new beat loads in that same cycle.

## Structure
- Shared package `stream_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} rr_state_t`.
  - `localparam SRC_A = 1'b0`, `SRC_B = 1'b1`.
- Sub-module: the existing `MUX` (parameter `WIDTH`), instantiated once for data select with `in_a = a_data`, `in_b = b_data`, `sel = sel`.
- `last` is selected in-block, not through `MUX`.

## Test plan
- Single source: A sends a 3-beat packet 0x11, 0x22, 0x33 (last on 0x33), B idle, `out_ready` = 1 → `out_data` shows 0x11, 0x22, 0x33 in cycles N+1..N+3 with `out_src` = 0 and `out_last` only on 0x33.
- Tie after reset: A and B both valid with single-beat packets (0xAA and 0xBB, last = 1) held every cycle → output order 0xAA, 0xBB, 0xAA, 0xBB with `out_src` alternating 0, 1, 0, 1.
- Lock: A starts a 4-beat packet, drops `a_valid` for 2 cycles after beat 2 while B is valid → `b_ready` stays 0 throughout, and B's first beat appears only after A's last beat.
- Backpressure: `out_ready` = 0 for 3 cycles with 0x5C loaded → `out_data` holds 0x5C, `out_valid` = 1, both readies 0. The next beat appears one cycle after `out_ready` returns high, with no loss or duplicate.
- Reset mid-packet: `rst_n` = 0 during beat 2 of a B packet → next cycle `out_valid` = 0 and readies = 0. After release, with both valid, A is granted first.
- Full throughput: both inputs stream 2-beat packets continuously with `out_ready` = 1 → `out_valid` high every cycle, and packets from A and B alternate with no interleaving inside a packet.
